// File: rtl/act_unit_pipe.sv
// Pipelined fixed-point activation unit (sigmoid/tanh/relu/identity).
// Three register stages behind a single valid/ready enable.
module act_unit_pipe #(
  parameter int IN_W     = 8,
  parameter int IN_FRAC  = 4,
  parameter int OUT_W    = 16,
  parameter int OUT_FRAC = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam int DW    = IN_FRAC + 1;
  localparam int QW    = 2 * DW;
  localparam int SH    = 2 * IN_FRAC - OUT_FRAC;
  localparam int FS    = OUT_FRAC - IN_FRAC;
  localparam int ONE_I = 1 << IN_FRAC;
  localparam int ONE_O = 1 << OUT_FRAC;

  localparam logic [IN_W+1:0] SIG_TH = (IN_W+2)'(4 << IN_FRAC);
  localparam logic [IN_W+1:0] TNH_TH = (IN_W+2)'(2 << IN_FRAC);
  localparam logic [IN_W-1:0] MAXP   = {1'b0, {(IN_W-1){1'b1}}};
  localparam logic [IN_W-1:0] MINN   = {1'b1, {(IN_W-1){1'b0}}};

  logic en;

  logic            v1_q, s1_q, sat1_q;
  logic [1:0]      m1_q;
  logic [IN_W-1:0] x1_q;
  logic [DW-1:0]   d1_q;

  logic            v2_q, s2_q, sat2_q;
  logic [1:0]      m2_q;
  logic [IN_W-1:0] x2_q;
  logic [QW-1:0]   q2_q;

  logic             out_valid_q, out_sat_q;
  logic [OUT_W-1:0] out_data_q;
  logic [CNT_W-1:0] cnt_q;

  logic            s1_d, sat1_d;
  logic [IN_W-1:0] a1;
  logic [DW-1:0]   d1_d;
  logic [QW-1:0]   sq2, q2_d;

  logic signed [OUT_W-1:0] one_o, qe, h, t, xe, res_d;

  assign en         = !out_valid_q | out_ready;
  assign in_ready   = en;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sat    = out_sat_q;
  assign sample_cnt = cnt_q;

  // S1: sign/magnitude with clamp, then distance-from-saturation term
  always_comb begin
    s1_d   = in_data[IN_W-1];
    a1     = s1_d ? (~in_data + 1'b1) : in_data;
    sat1_d = 1'b0;
    d1_d   = '0;
    if (in_data == MINN) begin
      a1     = MAXP;
      sat1_d = 1'b1;
    end
    case (in_mode)
      2'b00: begin
        if ({2'b00, a1} >= SIG_TH) sat1_d = 1'b1;
        else d1_d = DW'(ONE_I) - DW'(a1 >> 2);
      end
      2'b01: begin
        if ({2'b00, a1} >= TNH_TH) sat1_d = 1'b1;
        else d1_d = DW'(ONE_I) - DW'(a1 >> 1);
      end
      default: sat1_d = 1'b0;
    endcase
  end

  // S1 register
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      s1_q   <= 1'b0;
      sat1_q <= 1'b0;
      m1_q   <= '0;
      x1_q   <= '0;
      d1_q   <= '0;
    end else if (en) begin
      v1_q   <= in_valid;
      s1_q   <= s1_d;
      sat1_q <= sat1_d;
      m1_q   <= in_mode;
      x1_q   <= in_data;
      d1_q   <= d1_d;
    end
  end

  // S2: square the distance and align to output fraction
  always_comb begin
    sq2  = QW'(d1_q) * QW'(d1_q);
    q2_d = sq2 >> SH;
  end

  // S2 register
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q   <= 1'b0;
      s2_q   <= 1'b0;
      sat2_q <= 1'b0;
      m2_q   <= '0;
      x2_q   <= '0;
      q2_q   <= '0;
    end else if (en) begin
      v2_q   <= v1_q;
      s2_q   <= s1_q;
      sat2_q <= sat1_q;
      m2_q   <= m1_q;
      x2_q   <= x1_q;
      q2_q   <= q2_d;
    end
  end

  // S3: fold the quadratic into the selected activation
  always_comb begin
    one_o = OUT_W'(ONE_O);
    qe    = OUT_W'(q2_q);
    h     = qe >>> 1;
    t     = one_o - qe;
    xe    = OUT_W'($signed(x2_q)) <<< FS;
    case (m2_q)
      2'b00:   res_d = s2_q ? h : one_o - h;
      2'b01:   res_d = s2_q ? -t : t;
      2'b10:   res_d = s2_q ? '0 : xe;
      default: res_d = xe;
    endcase
  end

  // S3 output register; holds while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (en) begin
      out_valid_q <= v2_q;
      if (v2_q) begin
        out_data_q <= res_d;
        out_sat_q  <= sat2_q & ~m2_q[1];
      end
    end
  end

  // Completed-transfer counter, sticks at all-ones
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (out_valid_q && out_ready && cnt_q != '1)
      cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: tb/tb_act_unit_pipe.sv
// Directed bench for act_unit_pipe with an output scoreboard.
// Expected values come from constants and an integer reference model.
module tb_act_unit_pipe;

  typedef struct packed {
    logic [15:0] d;
    logic        s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic [15:0] sample_cnt;

  exp_t sb[$];
  int   n_asserts = 0;
  int   n_fail    = 0;
  int   cnt_exp   = 0;
  int   run       = 0;
  int   max_run   = 0;

  act_unit_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .sample_cnt (sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] x, input logic [1:0] m);
    int xi, a, d, q, r;
    bit s, sat;
    exp_t e;
    xi  = int'($signed(x));
    s   = xi < 0;
    a   = s ? -xi : xi;
    sat = 0;
    d   = 0;
    if (xi == -128) begin
      a   = 127;
      sat = 1;
    end
    if (m == 2'b00) begin
      if (a >= 64) sat = 1;
      else d = 16 - a / 4;
    end else if (m == 2'b01) begin
      if (a >= 32) sat = 1;
      else d = 16 - a / 2;
    end
    q = d * d;
    case (m)
      2'b00:   r = s ? q / 2 : 256 - q / 2;
      2'b01:   r = s ? q - 256 : 256 - q;
      2'b10:   r = s ? 0 : xi * 16;
      default: r = xi * 16;
    endcase
    if (m[1]) sat = 0;
    e.d = 16'(r);
    e.s = sat;
    return e;
  endfunction

  // Scoreboard: compare every output transfer against the queue head
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty", 0, 1);
      end else begin
        e = sb.pop_front();
        chk("out_data", int'($signed(out_data)), int'($signed(e.d)));
        chk("out_sat", int'(out_sat), int'(e.s));
      end
    end
    run = out_valid ? run + 1 : 0;
    if (run > max_run) max_run = run;
  end

  task automatic send(input int x, input logic [1:0] m,
                      input int ed, input logic es);
    exp_t e;
    int   g;
    in_valid = 1'b1;
    in_data  = 8'(x);
    in_mode  = m;
    @(negedge clk);
    g = 0;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    e.d = 16'(ed);
    e.s = es;
    sb.push_back(e);
    cnt_exp++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_m(input int x, input logic [1:0] m);
    exp_t e;
    e = model(8'(x), m);
    send(x, m, int'($signed(e.d)), e.s);
  endtask

  task automatic drain;
    int g;
    g = 0;
    while (sb.size() != 0 && g < 200) begin
      @(posedge clk);
      g++;
    end
    chk("drain", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    exp_t ea;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_sat", int'(out_sat), 0);
    chk("rst_sample_cnt", int'(sample_cnt), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_in_ready", int'(in_ready), 1);

    // Latency: first output three edges after the accepting edge
    in_valid = 1'b1;
    in_data  = 8'd0;
    in_mode  = 2'b00;
    @(negedge clk);
    chk("lat_ready", int'(in_ready), 1);
    ea.d = 16'd128;
    ea.s = 1'b0;
    sb.push_back(ea);
    cnt_exp++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, 3);
    drain();

    // Reference points
    send(24, 2'b00, 206, 1'b0);
    send(-24, 2'b00, 50, 1'b0);
    send(64, 2'b00, 256, 1'b1);
    send(-128, 2'b00, 0, 1'b1);
    send(16, 2'b01, 192, 1'b0);
    send(-16, 2'b01, -192, 1'b0);
    send(0, 2'b01, 0, 1'b0);
    send(40, 2'b01, 256, 1'b1);
    send(24, 2'b10, 384, 1'b0);
    send(-5, 2'b10, 0, 1'b0);
    send(-5, 2'b11, -80, 1'b0);
    send(-128, 2'b11, -2048, 1'b0);
    send(127, 2'b10, 2032, 1'b0);
    drain();
    chk("cnt_directed", int'(sample_cnt), cnt_exp);

    // Ten back-to-back beats
    max_run = 0;
    for (int i = 0; i < 10; i++)
      send_m(int'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
    drain();
    chk("burst_run", max_run, 10);
    chk("cnt_burst", int'(sample_cnt), cnt_exp);

    // Stall with the pipe full
    out_ready = 1'b0;
    send(24, 2'b00, 206, 1'b0);
    send(16, 2'b01, 192, 1'b0);
    send(-5, 2'b11, -80, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'd40;
    in_mode  = 2'b01;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_data", int'(out_data), 206);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(40, 2'b01, 256, 1'b1);
    drain();
    chk("cnt_stall", int'(sample_cnt), cnt_exp);

    // Reset with two samples in flight
    send(24, 2'b10, 384, 1'b0);
    send(-24, 2'b00, 50, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    cnt_exp = 0;
    chk("rstmid_valid", int'(out_valid), 0);
    chk("rstmid_cnt", int'(sample_cnt), 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("rstmid_no_stale", int'(out_valid), 0);
    end
    send_m(-3, 2'b01);
    send_m(70, 2'b00);
    drain();
    chk("cnt_after_rst", int'(sample_cnt), 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
